// File: rtl/range_counter_pkg.sv
// Shared encodings and helpers for range_counter and its prescaler.
package range_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/range_counter_prescaler.sv
// Divide-by-PRESCALE enable strobe for range_counter.
// Only compiled when RANGE_COUNTER_PRESCALE_EN is defined.
`ifdef RANGE_COUNTER_PRESCALE_EN
module counter_prescaler
    import range_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic strobe
);

    localparam int CNT_W = clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign strobe = advance && (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (strobe) begin
            cnt_next = '0;
        end else if (advance) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule
`endif

// File: rtl/range_counter.sv
// Run-time bounded up/down counter with wrap/saturate/one-shot boundary modes.
// Define RANGE_COUNTER_PRESCALE_EN to qualify counting with a divide-by-PRESCALE strobe.
module range_counter
    import range_counter_pkg::*;
#(
    parameter int          WIDTH      = 8,
    parameter int          STEP_W     = 4,
    parameter int unsigned INIT_VALUE = 0,
    parameter int          PRESCALE   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              start,
    input  logic              stop,
    input  logic              ena,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lower,
    input  logic [WIDTH-1:0]  upper,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  value,
    output logic              tc,
    output logic              busy,
    output logic              cfg_err
);

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VALUE);
    // One spare bit above the wider operand exposes carry and borrow.
    localparam int EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("range_counter: PRESCALE must be >= 1");
    end

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] value_reg, value_next;
    logic             tc_reg, tc_next;

    logic             count_qual;
    logic             count_step;
    logic [EXT_W-1:0] value_ext, step_ext, lower_ext, upper_ext;
    logic [EXT_W-1:0] sum_ext, diff_ext;
    logic             dn_borrow;
    logic             up_hit, up_exact, dn_hit, dn_exact;
    logic             bnd_hit, bnd_exact;
    logic             mode_sat, mode_oneshot;
    logic [WIDTH-1:0] step_result, bnd_value, load_clamped;

    assign cfg_err = lower > upper;
    assign busy    = (state_reg == ST_RUN);
    assign value   = value_reg;
    assign tc      = tc_reg;

`ifdef RANGE_COUNTER_PRESCALE_EN
    logic run_entry;
    logic presc_strobe;

    // Computed from inputs only so the divider clear never depends on the count result.
    assign run_entry = !clr && start && !stop && (state_reg != ST_RUN);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clr || load || run_entry),
        .advance ((state_reg == ST_RUN) && ena),
        .strobe  (presc_strobe)
    );

    assign count_qual = presc_strobe;
`else
    assign count_qual = ena;
`endif

    assign count_step = (state_reg == ST_RUN) && count_qual && (step != '0) && !cfg_err;

    assign value_ext = EXT_W'(value_reg);
    assign step_ext  = EXT_W'(step);
    assign lower_ext = EXT_W'(lower);
    assign upper_ext = EXT_W'(upper);
    assign sum_ext   = value_ext + step_ext;
    assign diff_ext  = value_ext - step_ext;
    assign dn_borrow = diff_ext[EXT_W-1];

    assign up_hit   = sum_ext >= upper_ext;
    assign up_exact = sum_ext == upper_ext;
    assign dn_hit   = dn_borrow || (diff_ext <= lower_ext);
    assign dn_exact = !dn_borrow && (diff_ext == lower_ext);

    assign bnd_hit   = (lower == upper) || (dir ? up_hit : dn_hit);
    assign bnd_exact = dir ? up_exact : dn_exact;

    assign mode_sat     = (mode == MODE_SAT) || (mode == 2'd3);
    assign mode_oneshot = (mode == MODE_ONESHOT);

    assign step_result = dir ? sum_ext[WIDTH-1:0] : diff_ext[WIDTH-1:0];

    // Exact hits and non-wrap overshoots land on the bound in the travel direction;
    // a wrap overshoot lands on the opposite bound with no remainder.
    always_comb begin
        bnd_value = dir ? upper : lower;
        if (lower == upper) begin
            bnd_value = upper;
        end else if (!bnd_exact && !(mode_sat || mode_oneshot)) begin
            bnd_value = dir ? lower : upper;
        end
    end

    assign load_clamped = (load_value > upper) ? upper :
                          (load_value < lower) ? lower : load_value;

    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        tc_next    = 1'b0;
        if (clr) begin
            state_next = ST_IDLE;
            value_next = INIT_V;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: if (start && !stop) state_next = ST_RUN;
                ST_RUN:           if (stop) state_next = ST_HALT;
                default:          state_next = ST_IDLE;
            endcase
            if (load) begin
                value_next = load_clamped;
            end else if (count_step) begin
                if (bnd_hit) begin
                    value_next = bnd_value;
                    tc_next    = 1'b1;
                    if (mode_oneshot) begin
                        state_next = ST_HALT;
                    end
                end else begin
                    value_next = step_result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            value_reg <= INIT_V;
            tc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            tc_reg    <= tc_next;
        end
    end

endmodule

// File: tb/tb_range_counter.sv
// Directed self-checking bench for range_counter (WIDTH=8, STEP_W=4, INIT_VALUE=0).
// Works in both builds; with RANGE_COUNTER_PRESCALE_EN each count needs PRESCALE enabled cycles.
module tb_range_counter;

`ifdef RANGE_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, clr, start, stop, ena, dir, load;
    logic [3:0] step;
    logic [1:0] mode;
    logic [7:0] lower, upper, load_value;
    logic [7:0] value;
    logic       tc, busy, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    range_counter #(
        .WIDTH      (8),
        .STEP_W     (4),
        .INIT_VALUE (0),
        .PRESCALE   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .start      (start),
        .stop       (stop),
        .ena        (ena),
        .dir        (dir),
        .step       (step),
        .mode       (mode),
        .lower      (lower),
        .upper      (upper),
        .load       (load),
        .load_value (load_value),
        .value      (value),
        .tc         (tc),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t value=%0d tc=%0b busy=%0b cfg_err=%0b", $time, value, tc, busy, cfg_err);
    endtask

    // One count step worth of qualifying cycles.
    task automatic step_tick();
        repeat (PS) tick();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (value !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got value=%0d busy=%0b tc=%0b expected 0/0/0", value, busy, tc);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        start = 1'b1; ena = 1'b1; step = 4'd1; dir = 1'b1; mode = 2'd0;
        lower = 8'd0; upper = 8'd255;
        tick();
        start = 1'b0;
        repeat (5 * PS) tick();
        n_checks++;
        if (value !== 8'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL count_5: got value=%0d busy=%0b expected 5/1", value, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (value !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got value=%0d busy=%0b tc=%0b expected 0/0/0", value, busy, tc);
        end
        tick();
        n_checks++;
        if (value !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got value=%0d busy=%0b tc=%0b expected 0/0/0", value, busy, tc);
        end
        rst_n = 1'b1;
        ena = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_v[5] = '{13, 16, 19, 10, 13};
        bit exp_t[5] = '{0, 0, 0, 1, 0};
        lower = 8'd10; upper = 8'd20; step = 4'd3; dir = 1'b1; mode = 2'd0;
        load = 1'b1; load_value = 8'd10;
        tick();
        load = 1'b0;
        n_checks++;
        if (value !== 8'd10 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_load: got value=%0d tc=%0b expected 10/0", value, tc);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            n_checks++;
            if (value !== exp_v[i][7:0] || tc !== exp_t[i]) begin
                n_fail++;
                $display("FAIL wrap_seq%0d: got value=%0d tc=%0b expected %0d/%0b", i, value, tc, exp_v[i], exp_t[i]);
            end
        end
        ena = 1'b0;
    endtask

    task automatic test_sat_down();
        lower = 8'd5; upper = 8'd50; dir = 1'b0; step = 4'd4; mode = 2'd1;
        load = 1'b1; load_value = 8'd9;
        tick();
        load = 1'b0;
        n_checks++;
        if (value !== 8'd9) begin
            n_fail++;
            $display("FAIL sat_load: got value=%0d expected 9", value);
        end
        ena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_tick();
            n_checks++;
            if (value !== 8'd5 || tc !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_seq%0d: got value=%0d tc=%0b busy=%0b expected 5/1/1", i, value, tc, busy);
            end
        end
        ena = 1'b0;
        tick();
        n_checks++;
        if (value !== 8'd5 || tc !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_idle: got value=%0d tc=%0b busy=%0b expected 5/0/1", value, tc, busy);
        end
    endtask

    task automatic test_oneshot();
        int exp_v[4] = '{2, 4, 6, 7};
        bit exp_t[4] = '{0, 0, 0, 1};
        bit exp_b[4] = '{1, 1, 1, 0};
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_halt: got busy=%0b expected 0", busy);
        end
        lower = 8'd0; upper = 8'd7; step = 4'd2; dir = 1'b1; mode = 2'd2;
        load = 1'b1; load_value = 8'd0;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_tick();
            n_checks++;
            if (value !== exp_v[i][7:0] || tc !== exp_t[i] || busy !== exp_b[i]) begin
                n_fail++;
                $display("FAIL oneshot_seq%0d: got value=%0d tc=%0b busy=%0b expected %0d/%0b/%0b",
                         i, value, tc, busy, exp_v[i], exp_t[i], exp_b[i]);
            end
        end
        repeat (3) tick();
        n_checks++;
        if (value !== 8'd7 || tc !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_hold: got value=%0d tc=%0b busy=%0b expected 7/0/0", value, tc, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        step_tick();
        n_checks++;
        if (value !== 8'd7 || tc !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_restart: got value=%0d tc=%0b busy=%0b expected 7/1/0", value, tc, busy);
        end
        ena = 1'b0;
    endtask

    task automatic test_priority();
        start = 1'b1;
        tick();
        start = 1'b0;
        lower = 8'd0; upper = 8'd255; step = 4'd1; dir = 1'b1; mode = 2'd0;
        clr = 1'b1; load = 1'b1; load_value = 8'd33; ena = 1'b1;
        tick();
        clr = 1'b0; load = 1'b0;
        n_checks++;
        if (value !== 8'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_over_load: got value=%0d busy=%0b tc=%0b expected 0/0/0", value, busy, tc);
        end
        repeat (PS) tick();
        n_checks++;
        if (value !== 8'd0) begin
            n_fail++;
            $display("FAIL idle_no_count: got value=%0d expected 0", value);
        end
        ena = 1'b0;
        upper = 8'd60; load = 1'b1; load_value = 8'd99;
        tick();
        n_checks++;
        if (value !== 8'd60 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp_hi: got value=%0d tc=%0b expected 60/0", value, tc);
        end
        lower = 8'd40; load_value = 8'd12;
        tick();
        load = 1'b0;
        n_checks++;
        if (value !== 8'd40 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp_lo: got value=%0d busy=%0b expected 40/0", value, busy);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_wins: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_equal_bounds();
        start = 1'b1;
        tick();
        start = 1'b0;
        lower = 8'd50; upper = 8'd50; mode = 2'd0; dir = 1'b1; step = 4'd1; ena = 1'b1;
        step_tick();
        n_checks++;
        if (value !== 8'd50 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL eq_bounds_up: got value=%0d tc=%0b expected 50/1", value, tc);
        end
        dir = 1'b0;
        step_tick();
        n_checks++;
        if (value !== 8'd50 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL eq_bounds_dn: got value=%0d tc=%0b expected 50/1", value, tc);
        end
        ena = 1'b0;
    endtask

    task automatic test_cfg_err();
        lower = 8'd30; upper = 8'd20; dir = 1'b1; ena = 1'b1;
        #1;
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_flag: got %0b expected 1", cfg_err);
        end
        repeat (2 * PS) tick();
        n_checks++;
        if (value !== 8'd50 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_freeze: got value=%0d tc=%0b expected 50/0", value, tc);
        end
        ena = 1'b0;
        lower = 8'd0; upper = 8'd60;
        #1;
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: got %0b expected 0", cfg_err);
        end
    endtask

    task automatic test_out_of_range();
        load = 1'b1; load_value = 8'd50;
        tick();
        load = 1'b0;
        upper = 8'd40; mode = 2'd1; dir = 1'b1; step = 4'd1; ena = 1'b1;
        step_tick();
        n_checks++;
        if (value !== 8'd40 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL above_upper: got value=%0d tc=%0b expected 40/1", value, tc);
        end
        ena = 1'b0;
    endtask

    task automatic test_prescale();
        lower = 8'd0; upper = 8'd255; mode = 2'd0; dir = 1'b1; step = 4'd1;
        load = 1'b1; load_value = 8'd0;
        tick();
        load = 1'b0;
        ena = 1'b1;
`ifdef RANGE_COUNTER_PRESCALE_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (value !== 8'd0) begin
                n_fail++;
                $display("FAIL presc_wait%0d: got value=%0d expected 0", i, value);
            end
        end
        tick();
        n_checks++;
        if (value !== 8'd1) begin
            n_fail++;
            $display("FAIL presc_fire: got value=%0d expected 1", value);
        end
`else
        tick();
        n_checks++;
        if (value !== 8'd1) begin
            n_fail++;
            $display("FAIL direct_ena1: got value=%0d expected 1", value);
        end
        tick();
        n_checks++;
        if (value !== 8'd2) begin
            n_fail++;
            $display("FAIL direct_ena2: got value=%0d expected 2", value);
        end
`endif
        ena = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0; ena = 1'b0;
        dir = 1'b1; load = 1'b0; step = 4'd0; mode = 2'd0;
        lower = 8'd0; upper = 8'd255; load_value = 8'd0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_oneshot();
        test_priority();
        test_equal_bounds();
        test_cfg_err();
        test_out_of_range();
        test_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
